// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: unsigned binary to packed BCD with start/ready/done handshake.
// Optional build macro BCD_SATURATE_EN: on overflow the result shows all nines instead of value mod 10^DIGITS.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned     BCD_W   = 4 * DIGITS;
  localparam int unsigned     CNT_W   = $clog2(BIN_W + 1);
  localparam longint unsigned BCD_MAX = pow10(DIGITS) - 1;
  localparam int unsigned     MAX_W   = $clog2(BCD_MAX + 1);
  localparam int unsigned     CMP_W   = (BIN_W > MAX_W) ? BIN_W : MAX_W;
  localparam logic [CMP_W-1:0] LIMIT  = CMP_W'(BCD_MAX);
`ifdef BCD_SATURATE_EN
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scr_q, scr_d, adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_d;
  logic               ovf_d, done_d, ready_d, busy_d;
  logic               ovf_next_c;

  assign ovf_next_c = CMP_W'(bin) > LIMIT;

  // Add-3 correction on every scratch digit that would exceed 9 after doubling
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd;
    ovf_d      = ovf;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d      = bin;
          scr_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_pend_d = ovf_next_c;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Bit leaving the top digit is dropped, leaving value mod 10^DIGITS
        {scr_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
`ifdef BCD_SATURATE_EN
        bcd_d = ovf_pend_q ? ALL_NINES : scr_q;
`else
        bcd_d = scr_q;
`endif
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
      done       <= 1'b0;
      ready      <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd        <= bcd_d;
      ovf        <= ovf_d;
      done       <= done_d;
      ready      <= ready_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: arithmetic reference model checked every cycle plus directed literal checks.
// Honours BCD_SATURATE_EN the same way as the design build.
module tb_bin2bcd_seq;
  localparam int unsigned BIN_W  = 10;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned BCD_W  = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [BIN_W-1:0] bin;
  logic             ready, busy, done, ovf;
  logic [BCD_W-1:0] bcd;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Decimal digits from plain division; saturate build shows 999 on overflow
  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [BCD_W-1:0] r;
    int m;
    r = '0;
    m = v % 1000;
    r[3:0]  = 4'(m % 10);
    r[7:4]  = 4'((m / 10) % 10);
    r[11:8] = 4'(m / 100);
`ifdef BCD_SATURATE_EN
    if (v > 999) r = 12'h999;
`endif
    return r;
  endfunction

  // Reference model: a conversion occupies BIN_W+2 cycles, result appears at the end
  int               m_t = -1;
  int               m_cap = 0;
  logic [BCD_W-1:0] m_bcd = '0;
  logic             m_ovf = 1'b0;
  logic             m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_t = -1; m_bcd = '0; m_ovf = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_t < 0) begin
        if (start) begin m_cap = int'(bin); m_t = 0; end
      end else begin
        m_t++;
        if (m_t == int'(BIN_W) + 1) begin
          m_bcd = to_bcd(m_cap); m_ovf = (m_cap > 999); m_done = 1'b1; m_t = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ready), 32'(m_t < 0));
      chk("busy",  32'(busy),  32'(m_t >= 0 && m_t < int'(BIN_W)));
      chk("done",  32'(done),  32'(m_done));
      chk("bcd",   32'(bcd),   32'(m_bcd));
      chk("ovf",   32'(ovf),   32'(m_ovf));
    end
  end

  // One conversion with literal expectations on result, latency and busy length
  task automatic convert(input int v, input logic [BCD_W-1:0] e_bcd, input logic e_ovf);
    int k, nb;
    k = 0; nb = 0;
    @(negedge clk);
    start = 1'b1; bin = BIN_W'(v);
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (k == 1) start = 1'b0;
      if (busy) nb++;
      if (done) break;
    end
    chk("lat_done", 32'(k), 32'd12);
    chk("busy_len", 32'(nb), 32'd10);
    chk("lit_bcd", 32'(bcd), 32'(e_bcd));
    chk("lit_ovf", 32'(ovf), 32'(e_ovf));
    @(negedge clk);
    chk("done_1cyc", 32'(done), 32'd0);
  endtask

  initial begin
    int k, nd, prev_acc, ndone;
    int dt [3];
    logic [BCD_W-1:0] e3 [3];

    rst = 1'b1; start = 1'b0; bin = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0; chk_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_busy",  32'(busy),  32'd0);
    chk("idle_done",  32'(done),  32'd0);
    chk("idle_bcd",   32'(bcd),   32'h000);
    chk("idle_ovf",   32'(ovf),   32'd0);

    convert(0,   12'h000, 1'b0);
    convert(255, 12'h255, 1'b0);
    convert(999, 12'h999, 1'b0);
`ifdef BCD_SATURATE_EN
    convert(1023, 12'h999, 1'b1);
    convert(1000, 12'h999, 1'b1);
`else
    convert(1023, 12'h023, 1'b1);
    convert(1000, 12'h000, 1'b1);
`endif
    convert(7, 12'h007, 1'b0);

    // Start requests while busy are ignored
    @(negedge clk);
    start = 1'b1; bin = BIN_W'(123);
    @(negedge clk); start = 1'b0;
    ndone = 0; k = 1;
    while (k < 40) begin
      if (k == 3 || k == 7) begin start = 1'b1; bin = BIN_W'(456); end
      else start = 1'b0;
      @(negedge clk);
      k++;
      if (done) begin ndone++; chk("busy_ign_bcd", 32'(bcd), 32'h123); end
    end
    chk("busy_ign_pulses", 32'(ndone), 32'd1);

    // Back-to-back with start held high
    e3[0] = 12'h001; e3[1] = 12'h002; e3[2] = 12'h003;
    @(negedge clk);
    start = 1'b1; bin = BIN_W'(1);
    nd = 0; k = 0; prev_acc = int'(ready);
    while (nd < 3 && k < 80) begin
      @(negedge clk);
      k++;
      if (prev_acc != 0) bin = bin + BIN_W'(1);
      if (done) begin
        chk("b2b_bcd", 32'(bcd), 32'(e3[nd]));
        dt[nd] = k; nd++;
        if (nd == 3) start = 1'b0;
      end
      prev_acc = int'(ready && start);
    end
    chk("b2b_count", 32'(nd), 32'd3);
    chk("b2b_gap1", 32'(dt[1] - dt[0]), 32'd12);
    chk("b2b_gap2", 32'(dt[2] - dt[1]), 32'd12);
    repeat (15) @(negedge clk);

    // Reset in the 5th SHIFT cycle aborts the conversion
    start = 1'b1; bin = BIN_W'(777);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_bcd",   32'(bcd),   32'h000);
    chk("rst_ovf",   32'(ovf),   32'd0);
    ndone = 0;
    repeat (15) begin @(negedge clk); if (done) ndone++; end
    chk("rst_no_done", 32'(ndone), 32'd0);
    convert(42, 12'h042, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
